// File: rtl/axi_rd_sram_slave_pkg.sv
// Shared AXI definitions for the read-side memory and cache blocks.
//   rd_state_t   : read-burst FSM state encoding (IDLE / WAIT / BURST)
//   RRESP_OKAY   : RRESP code for a good beat
//   RRESP_SLVERR : RRESP code for an out-of-range beat
//   rresp_for()  : maps a range-check result to its RRESP code
package axi_rd_sram_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } rd_state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    function automatic logic [1:0] rresp_for(input logic in_range);
        return in_range ? RRESP_OKAY : RRESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_rd_sram_slave_sram_1r1w.sv
// sram_1r1w: word-addressed 32-bit storage, one synchronous write port and
// one combinational read port. Contents are never reset.
//   clk     : clock, write on posedge
//   i_we    : write enable
//   i_waddr : write word index
//   i_wdata : write data
//   i_raddr : read word index
//   o_rdata : read data (reflects contents before a same-edge write)
module sram_1r1w #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_rd_sram_slave.sv
// axi_rd_sram_slave: AXI read-only slave (INCR bursts, one outstanding)
// serving a preloadable on-chip word memory.
//   clk, rst              : clock; synchronous active-high reset
//   s_arvalid/s_arready   : read request handshake
//   s_araddr, s_arlen     : burst start byte address, beats minus one
//   s_rvalid/s_rready     : read beat handshake
//   s_rdata, s_rresp      : beat data and response (OKAY / SLVERR)
//   s_rlast               : final beat of the burst
//   ld_we/ld_addr/ld_data : preload write port (byte address, any state)
module axi_rd_sram_slave
    import axi_rd_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [7:0]  s_arlen,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);

    rd_state_t   r_state;
    logic [31:0] r_addr;     // byte address of the next beat to fetch
    logic [7:0]  r_len;
    logic [7:0]  r_beat;     // index of the beat currently presented
    logic [3:0]  r_lat;
    logic        r_arready;
    logic        r_rvalid;
    logic        r_rlast;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    // Offsets are taken modulo 2^32, so one unsigned compare covers both
    // bounds and a wrapped beat address can never alias to word 0.
    logic [31:0]   w_rd_off;
    logic          w_rd_in;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_mem_q;
    logic [31:0]   w_ld_off;
    logic          w_ld_in;
    logic [AW-1:0] w_ld_idx;

    assign w_rd_off = r_addr - BASE_ADDR;
    assign w_rd_in  = (w_rd_off < MEM_BYTES);
    assign w_rd_idx = w_rd_off[AW+1:2];
    assign w_ld_off = ld_addr - BASE_ADDR;
    assign w_ld_in  = (w_ld_off < MEM_BYTES);
    assign w_ld_idx = w_ld_off[AW+1:2];

    sram_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (ld_we && w_ld_in),
        .i_waddr (w_ld_idx),
        .i_wdata (ld_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_q)
    );

    // Beat data is captured from the combinational read port on the same
    // edge a preload write lands, so a colliding write yields old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RRESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_arvalid) begin
                        r_addr    <= s_araddr & ~32'h3;
                        r_len     <= s_arlen;
                        r_lat     <= LAT_LOAD;
                        r_arready <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_rdata  <= w_rd_in ? w_mem_q : '0;
                        r_rresp  <= rresp_for(w_rd_in);
                        r_addr   <= r_addr + 32'd4;
                        r_beat   <= '0;
                        r_rlast  <= (r_len == 8'd0);
                        r_rvalid <= 1'b1;
                        r_state  <= ST_BURST;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                ST_BURST: begin
                    if (s_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_rdata <= w_rd_in ? w_mem_q : '0;
                            r_rresp <= rresp_for(w_rd_in);
                            r_addr  <= r_addr + 32'd4;
                            r_beat  <= r_beat + 8'd1;
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rlast   = r_rlast;

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
// Scoreboard bench for axi_rd_sram_slave: the driver pushes the expected
// beats of each burst (computed from a word-array memory model) into a
// queue; a negedge monitor compares every presented beat against the head.
module tb_axi_rd_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        ld_we = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    axi_rd_sram_slave #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        first;
        int          hs_cyc;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mb;
    logic [31:0] model_mem [DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rr_mode  = 0;
    int          rr_idx   = 0;
    logic        prev_more  = 1'b0;
    logic        prev_last  = 1'b0;
    logic        front_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
        longint unsigned lo, hi, x;
        lo = BASE;
        hi = lo + 4 * DEPTH;
        x  = a;
        return (x >= lo) && (x < hi);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic push_burst(input logic [31:0] addr, input logic [7:0] len, input int hs);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            beat_t b;
            a = (addr & ~32'h3) + 32'(4 * i);
            b.first  = (i == 0);
            b.last   = (i == int'(len));
            b.hs_cyc = hs;
            if (in_range(a)) begin
                b.data = model_mem[widx(a)];
                b.resp = 2'b00;
            end else begin
                b.data = '0;
                b.resp = 2'b10;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
        if (in_range(a)) model_mem[widx(a)] = d;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len);
        int waited;
        waited = 0;
        s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        @(negedge clk);
        while (!s_arready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!s_arready) begin
            chk("ar_accept_timeout", 32'(s_arready), 32'd1);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        push_burst(addr, len, cyc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("burst_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_arready", 32'(s_arready), 32'd1);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rlast", 32'(s_rlast), 32'd0);
        chk("rst_rresp", 32'(s_rresp), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
    endtask

    // rready generator: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
    initial forever begin
        @(posedge clk); #1;
        case (rr_mode)
            0: s_rready = 1'b1;
            1: begin
                s_rready = ((rr_idx % 4) == 0) || ((rr_idx % 4) == 3);
                rr_idx++;
            end
            default: s_rready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: whatever the DUT presents must equal the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_more  = 1'b0;
            prev_last  = 1'b0;
            front_seen = 1'b0;
        end else begin
            if (prev_last) begin
                chk("arready_after_last", 32'(s_arready), 32'd1);
                chk("rvalid_after_last", 32'(s_rvalid), 32'd0);
            end
            if (prev_more) chk("zero_bubble", 32'(s_rvalid), 32'd1);
            prev_more = 1'b0;
            prev_last = 1'b0;
            if (exp_q.size() != 0) chk("arready_busy", 32'(s_arready), 32'd0);
            if (s_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(s_rvalid), 32'd0);
                end else begin
                    mb = exp_q[0];
                    if (mb.first && !front_seen)
                        chk("first_latency", 32'(cyc - mb.hs_cyc), 32'(LAT));
                    front_seen = 1'b1;
                    chk("rdata", s_rdata, mb.data);
                    chk("rresp", 32'(s_rresp), 32'(mb.resp));
                    chk("rlast", 32'(s_rlast), 32'(mb.last));
                    if (s_rready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                        prev_more  = !mb.last;
                        prev_last  = mb.last;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) ld_write(BASE + 32'(4 * i), $urandom);
        ld_write(BASE + 32'd0,  32'd11);
        ld_write(BASE + 32'd4,  32'd22);
        ld_write(BASE + 32'd8,  32'd33);
        ld_write(BASE + 32'd12, 32'd44);

        // Full-throughput 4-beat burst
        rr_mode = 0;
        do_ar(BASE, 8'd3);
        wait_drain();

        // Same burst under rready 1,0,0,1,...
        rr_mode = 1; rr_idx = 0;
        do_ar(BASE, 8'd3);
        wait_drain();
        rr_mode = 0;

        // Crossing the top of memory, then a far out-of-range single beat
        do_ar(BASE + 32'h3F8, 8'd3);
        wait_drain();
        do_ar(32'h0F00_0004, 8'd0);
        wait_drain();

        // Address arithmetic wrapping past 32'hFFFF_FFFC
        do_ar(32'hFFFF_FFF8, 8'd3);
        wait_drain();

        // Longest burst
        do_ar(BASE, 8'd255);
        wait_drain();

        // Out-of-range preloads must not land anywhere
        ld_write(BASE - 32'd4, 32'hDEAD_0001);
        ld_write(BASE + 32'(4 * DEPTH), 32'hDEAD_0002);
        do_ar(BASE, 8'd0);
        wait_drain();
        do_ar(BASE + 32'(4 * (DEPTH - 1)), 8'd0);
        wait_drain();

        // Reset during beat 2 of a 4-beat burst
        do_ar(BASE, 8'd3);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        do_ar(BASE + 32'd8, 8'd1);
        wait_drain();

        // Preload write colliding with capture of word 1
        do_ar(BASE + 32'd4, 8'd1);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        ld_we = 1'b1; ld_addr = BASE + 32'd4; ld_data = 32'h5555_5555;
        @(posedge clk); #1;
        ld_we = 1'b0;
        model_mem[1] = 32'h5555_5555;
        wait_drain();
        do_ar(BASE + 32'd4, 8'd0);
        wait_drain();

        // Randomized bursts
        for (int t = 0; t < 30; t++) begin
            logic [31:0] a;
            logic [7:0]  l;
            if ($urandom_range(0, 3) != 0)
                ld_write(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), $urandom);
            else
                ld_write($urandom, $urandom);
            case ($urandom_range(0, 3))
                0: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                1: a = BASE + 32'(4 * DEPTH) - 32'(4 * $urandom_range(0, 8));
                2: a = BASE - 32'(4 * $urandom_range(0, 4));
                default: a = $urandom;
            endcase
            a = a | 32'($urandom_range(0, 3));
            l = 8'($urandom_range(0, 15));
            rr_mode = $urandom_range(0, 2);
            rr_idx = 0;
            do_ar(a, l);
            wait_drain();
        end
        rr_mode = 0;

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
